// File: rtl/clock_period_monitor.sv
// Measures period and high time of a slow clock (sig_in) in clk_in cycles and
// tracks lock against a nominal period, with a sticky no-edge timeout.
module clock_period_monitor #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned EXPECTED_PERIOD = 202,
    parameter int unsigned TOLERANCE       = 2,
    parameter int unsigned LOCK_COUNT      = 4,
    parameter int unsigned TIMEOUT         = 1024
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  sig_in,
    output logic [DATA_WIDTH-1:0] period_out,
    output logic [DATA_WIDTH-1:0] high_out,
    output logic                  meas_valid,
    output logic                  locked,
    output logic                  timeout
);

    localparam int unsigned MC_W = $clog2(LOCK_COUNT + 1);

    localparam logic signed [DATA_WIDTH:0] EXP_S   = (DATA_WIDTH+1)'(EXPECTED_PERIOD);
    localparam logic signed [DATA_WIDTH:0] TOL_S   = (DATA_WIDTH+1)'(TOLERANCE);
    localparam logic [DATA_WIDTH-1:0]      TO_C    = DATA_WIDTH'(TIMEOUT);
    localparam logic [DATA_WIDTH-1:0]      ONE_C   = DATA_WIDTH'(1);
    localparam logic [MC_W-1:0]            LOCK_C  = MC_W'(LOCK_COUNT);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t                state;
    logic                  sig_meta_p0;
    logic                  sig_s_p1;
    logic                  sig_d_p2;
    logic                  rise;
    logic                  fall;
    logic [DATA_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] hi_cap;
    logic [MC_W-1:0]       match_cnt;
    logic [MC_W-1:0]       match_nxt;

    // One extra bit keeps the difference exact for any counter value.
    function automatic logic within_tol(input logic [DATA_WIDTH-1:0] c);
        logic signed [DATA_WIDTH:0] d;
        d = signed'({1'b0, c}) - EXP_S;
        if (d < 0) begin
            d = -d;
        end
        return (d <= TOL_S);
    endfunction

    function automatic logic [MC_W-1:0] sat_inc(input logic [MC_W-1:0] v);
        return (v >= LOCK_C) ? LOCK_C : v + 1'b1;
    endfunction

    // Edge detect on the synchronised input, three clk_in cycles behind sig_in.
    assign rise      = sig_s_p1 & ~sig_d_p2;
    assign fall      = ~sig_s_p1 & sig_d_p2;
    assign match_nxt = sat_inc(match_cnt);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sig_meta_p0 <= 1'b0;
            sig_s_p1    <= 1'b0;
            sig_d_p2    <= 1'b0;
            cnt         <= '0;
            hi_cap      <= '0;
            match_cnt   <= '0;
            period_out  <= '0;
            high_out    <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            sig_meta_p0 <= sig_in;
            sig_s_p1    <= sig_meta_p0;
            sig_d_p2    <= sig_s_p1;
            meas_valid  <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rise) begin
                        state   <= MEASURE;
                        cnt     <= ONE_C;
                        timeout <= 1'b0;
                    end
                end

                MEASURE: begin
                    if (fall) begin
                        hi_cap <= cnt;
                    end
                    // A rise on the timeout cycle still counts as a measurement.
                    if (rise) begin
                        period_out <= cnt;
                        high_out   <= hi_cap;
                        meas_valid <= 1'b1;
                        cnt        <= ONE_C;
                        if (within_tol(cnt)) begin
                            match_cnt <= match_nxt;
                            if (match_nxt == LOCK_C) begin
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                            locked    <= 1'b0;
                        end
                    end else if (cnt == TO_C) begin
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_period_monitor.sv
// Scoreboard bench for clock_period_monitor: a reference model pushes the expected
// measurement at each driven rise; a negedge monitor pops and compares on meas_valid.
module tb_clock_period_monitor;

    localparam int DW  = 32;
    localparam int EXP = 202;
    localparam int TOL = 2;
    localparam int LC  = 4;
    localparam int TO  = 1024;

    logic          clk_in = 1'b0;
    logic          rst_n  = 1'b0;
    logic          sig_in = 1'b0;
    logic [DW-1:0] period_out;
    logic [DW-1:0] high_out;
    logic          meas_valid;
    logic          locked;
    logic          timeout;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] p;
        logic [31:0] h;
        logic        lk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    bit   m_active = 1'b0;
    int   m_prev_p = 0;
    int   m_prev_h = 0;
    int   m_match  = 0;
    logic m_lock   = 1'b0;

    always #5 clk_in = ~clk_in;

    clock_period_monitor #(
        .DATA_WIDTH     (DW),
        .EXPECTED_PERIOD(EXP),
        .TOLERANCE      (TOL),
        .LOCK_COUNT     (LC),
        .TIMEOUT        (TO)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period_out(period_out),
        .high_out  (high_out),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, want);
        end
    endtask

    // Reference model: a new rise closes the previous period.
    task automatic model_rise(input int p, input int h);
        exp_t e;
        if (m_active) begin
            if (m_prev_p > TO) begin
                m_match = 0;
                m_lock  = 1'b0;
            end else begin
                if (m_prev_p >= EXP - TOL && m_prev_p <= EXP + TOL) begin
                    if (m_match < LC) m_match++;
                end else begin
                    m_match = 0;
                end
                m_lock = (m_match == LC);
                e.p  = m_prev_p;
                e.h  = m_prev_h;
                e.lk = m_lock;
                sb.push_back(e);
            end
        end
        m_active = 1'b1;
        m_prev_p = p;
        m_prev_h = h;
    endtask

    task automatic drive_period(input int p, input int h);
        model_rise(p, h);
        sig_in = 1'b1;
        repeat (h) @(posedge clk_in);
        #1 sig_in = 1'b0;
        repeat (p - h) @(posedge clk_in);
        #1;
    endtask

    // Same as drive_period, but samples timeout just before and just after rise detection.
    task automatic drive_chk(input int p, input int h, input logic t_pre, input logic t_post,
                             input string tag);
        model_rise(p, h);
        sig_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 chk({tag, "_pre"}, 32'(timeout), 32'(t_pre));
        repeat (3) @(posedge clk_in);
        #1 chk({tag, "_post"}, 32'(timeout), 32'(t_post));
        repeat (h - 5) @(posedge clk_in);
        #1 sig_in = 1'b0;
        repeat (p - h) @(posedge clk_in);
        #1;
    endtask

    task automatic hold_low(input int n);
        repeat (n) @(posedge clk_in);
        #1;
        m_prev_p += n;
    endtask

    always @(negedge clk_in) begin
        if (rst_n && meas_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(meas_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("period", period_out, mon_e.p);
                chk("high", high_out, mon_e.h);
                chk("locked_at_valid", 32'(locked), 32'(mon_e.lk));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_period", period_out, 0);
        chk("rst_high", high_out, 0);
        chk("rst_valid", 32'(meas_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_timeout", 32'(timeout), 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;

        // Nominal square wave: lock on the fourth measurement.
        for (int i = 0; i < 5; i++) drive_period(202, 101);
        chk("lock_nominal", 32'(locked), 1);
        chk("period_nominal", period_out, 202);

        // One long period drops lock, then five nominal periods relock.
        drive_period(210, 105);
        drive_period(202, 101);
        chk("unlock_210", 32'(locked), 0);
        chk("period_210", period_out, 210);
        for (int i = 0; i < 4; i++) drive_period(202, 101);
        chk("relock", 32'(locked), 1);

        // Tolerance edges 204/200 count as matches, 205 does not.
        drive_period(205, 102);
        drive_period(204, 102);
        drive_period(200, 100);
        drive_period(202, 101);
        drive_period(201, 100);
        chk("not_yet_locked", 32'(locked), 0);
        drive_period(205, 102);
        chk("lock_via_tol_edges", 32'(locked), 1);
        drive_period(202, 101);
        chk("unlock_205", 32'(locked), 0);

        // Lock, then starve the input until timeout.
        for (int i = 0; i < 4; i++) drive_period(202, 101);
        chk("lock_before_starve", 32'(locked), 1);
        hold_low(790);
        chk("no_timeout_yet", 32'(timeout), 0);
        hold_low(310);
        chk("timeout_set", 32'(timeout), 1);
        chk("timeout_unlock", 32'(locked), 0);
        drive_chk(202, 101, 1'b1, 1'b0, "tmo_clear");
        drive_period(202, 101);
        chk("locked_after_tmo", 32'(locked), 0);

        // Period exactly TIMEOUT is measured; one more cycle times out.
        drive_period(1024, 512);
        drive_period(202, 101);
        chk("p1024_timeout", 32'(timeout), 0);
        chk("p1024_period", period_out, 1024);
        drive_chk(1025, 512, 1'b0, 1'b0, "p1025_start");
        drive_chk(202, 101, 1'b1, 1'b0, "p1025_end");
        drive_period(202, 101);

        // Asynchronous reset in the middle of a measurement.
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_period", period_out, 0);
        chk("async_rst_high", high_out, 0);
        chk("async_rst_valid", 32'(meas_valid), 0);
        chk("async_rst_locked", 32'(locked), 0);
        chk("async_rst_timeout", 32'(timeout), 0);
        m_active = 1'b0;
        m_match  = 0;
        m_lock   = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk_in);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        drive_period(202, 101);
        drive_period(202, 101);
        chk("post_rst_period", period_out, 202);

        repeat (10) @(posedge clk_in);
        #1 chk("sb_drain", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
